// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline constants, branch hazard FSM encoding and register-match helper
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT2 = 2'd1,
        ST_WAIT1 = 2'd2
    } bh_state_e;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $0 is hardwired, so a write to it can never be a true dependency
    function automatic logic reg_hit(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       we
    );
        return we && (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch comparator scheduler: forwarding selects, counted stalls, perf counters
module branch_hazard_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   BranchD,
    input  logic                   UseRtD,
    input  logic [4:0]             RsD,
    input  logic [4:0]             RtD,
    input  logic                   RegWriteE,
    input  logic                   MemtoRegE,
    input  logic [4:0]             WriteRegE,
    input  logic                   RegWriteM,
    input  logic                   MemtoRegM,
    input  logic [4:0]             WriteRegM,
    input  logic                   RegWriteW,
    input  logic [4:0]             WriteRegW,
    input  logic                   FlushD,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   FlushE,
    output logic [1:0]             FwdAD,
    output logic [1:0]             FwdBD,
    output logic                   BranchResolve,
    output logic [STALL_CNT_W-1:0] BranchCount,
    output logic [STALL_CNT_W-1:0] StallCycles
);

    import mips_pkg::*;

    bh_state_e state_q;
    bh_state_e state_d;

    logic load_in_e;
    logic alu_in_e;
    logic load_in_m;
    logic need2;
    logic need1;
    logic stall;
    logic resolve;

    always_comb begin
        load_in_e = reg_hit(RsD, WriteRegE, RegWriteE && MemtoRegE)
                 || (UseRtD && reg_hit(RtD, WriteRegE, RegWriteE && MemtoRegE));
        alu_in_e  = reg_hit(RsD, WriteRegE, RegWriteE)
                 || (UseRtD && reg_hit(RtD, WriteRegE, RegWriteE));
        load_in_m = reg_hit(RsD, WriteRegM, RegWriteM && MemtoRegM)
                 || (UseRtD && reg_hit(RtD, WriteRegM, RegWriteM && MemtoRegM));
        need2     = load_in_e;
        need1     = alu_in_e || load_in_m;
    end

    // Flush and reset both override the countdown and silence the stall outputs
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        resolve = 1'b0;
        if (!rst_n || FlushD) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (BranchD) begin
                        if (need2) begin
                            stall   = 1'b1;
                            state_d = ST_WAIT2;
                        end else if (need1) begin
                            stall   = 1'b1;
                            state_d = ST_WAIT1;
                        end else begin
                            resolve = 1'b1;
                        end
                    end
                end
                ST_WAIT2: begin
                    stall   = 1'b1;
                    state_d = ST_WAIT1;
                end
                ST_WAIT1: begin
                    resolve = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // MEM beats WB; a load in MEM has no data yet, so it is not a forwarding source
    always_comb begin
        FwdAD = FWD_RF;
        if (reg_hit(RsD, WriteRegM, RegWriteM && !MemtoRegM)) begin
            FwdAD = FWD_M;
        end else if (reg_hit(RsD, WriteRegW, RegWriteW)) begin
            FwdAD = FWD_W;
        end

        FwdBD = FWD_RF;
        if (UseRtD) begin
            if (reg_hit(RtD, WriteRegM, RegWriteM && !MemtoRegM)) begin
                FwdBD = FWD_M;
            end else if (reg_hit(RtD, WriteRegW, RegWriteW)) begin
                FwdBD = FWD_W;
            end
        end
    end

    assign StallF        = stall;
    assign StallD        = stall;
    assign FlushE        = stall;
    assign BranchResolve = resolve;

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (resolve),
        .count (BranchCount)
    );

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .count (StallCycles)
    );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - self-checking bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       BranchD, UseRtD;
    logic [4:0] RsD, RtD;
    logic       RegWriteE, MemtoRegE;
    logic [4:0] WriteRegE;
    logic       RegWriteM, MemtoRegM;
    logic [4:0] WriteRegM;
    logic       RegWriteW;
    logic [4:0] WriteRegW;
    logic       FlushD;

    logic        StallF, StallD, FlushE, BranchResolve;
    logic [1:0]  FwdAD, FwdBD;
    logic [15:0] BranchCount, StallCycles;

    logic        StallF_2, StallD_2, FlushE_2, BranchResolve_2;
    logic [1:0]  FwdAD_2, FwdBD_2;
    logic [1:0]  BranchCount_2, StallCycles_2;

    int checks = 0;
    int errors = 0;

    int q[$];
    int m_bc;
    int m_sc;
    localparam int CNT_MAX = 65535;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .BranchD(BranchD), .UseRtD(UseRtD),
        .RsD(RsD), .RtD(RtD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .FlushD(FlushD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .FwdAD(FwdAD), .FwdBD(FwdBD), .BranchResolve(BranchResolve),
        .BranchCount(BranchCount), .StallCycles(StallCycles)
    );

    branch_hazard_ctrl #(.STALL_CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .BranchD(BranchD), .UseRtD(UseRtD),
        .RsD(RsD), .RtD(RtD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .WriteRegM(WriteRegM),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .FlushD(FlushD),
        .StallF(StallF_2), .StallD(StallD_2), .FlushE(FlushE_2),
        .FwdAD(FwdAD_2), .FwdBD(FwdBD_2), .BranchResolve(BranchResolve_2),
        .BranchCount(BranchCount_2), .StallCycles(StallCycles_2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_fwd(input logic [4:0] r);
        if (r == 0) return 0;
        if (RegWriteM && !MemtoRegM && WriteRegM == r) return 1;
        if (RegWriteW && WriteRegW == r) return 2;
        return 0;
    endfunction

    // Cycles until the producer's value reaches a forwardable stage
    function automatic int ref_demand();
        int n;
        logic [4:0] used[$];
        n = 0;
        used.push_back(RsD);
        if (UseRtD) used.push_back(RtD);
        foreach (used[i]) begin
            if (used[i] != 0) begin
                if (RegWriteE && WriteRegE == used[i]) n = (MemtoRegE && n < 2) ? 2 : (n < 1 ? 1 : n);
                if (RegWriteM && MemtoRegM && WriteRegM == used[i] && n < 1) n = 1;
            end
        end
        return n;
    endfunction

    // Model: a queue of scheduled per-cycle actions (1 = stall, 2 = resolve)
    task automatic sample();
        int exp_stall, exp_res, efa, efb, act, n;
        #1;
        chk("branch_count", int'(BranchCount), m_bc);
        chk("stall_cycles", int'(StallCycles), m_sc);
        efa = ref_fwd(RsD);
        efb = UseRtD ? ref_fwd(RtD) : 0;
        exp_stall = 0;
        exp_res   = 0;
        if (!rst_n || FlushD) begin
            q.delete();
        end else if (q.size() > 0) begin
            act = q.pop_front();
            exp_stall = (act == 1);
            exp_res   = (act == 2);
        end else if (BranchD) begin
            n = ref_demand();
            if (n == 0) begin
                exp_res = 1;
            end else begin
                exp_stall = 1;
                for (int k = 1; k < n; k++) q.push_back(1);
                q.push_back(2);
            end
        end
        chk("stall_f", int'(StallF), exp_stall);
        chk("stall_d", int'(StallD), exp_stall);
        chk("flush_e", int'(FlushE), exp_stall);
        chk("branch_resolve", int'(BranchResolve), exp_res);
        chk("fwd_a", int'(FwdAD), efa);
        chk("fwd_b", int'(FwdBD), efb);
        if (!rst_n) begin
            m_bc = 0;
            m_sc = 0;
        end else begin
            if (exp_res && m_bc < CNT_MAX) m_bc++;
            if (exp_stall && m_sc < CNT_MAX) m_sc++;
        end
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        BranchD = 0; UseRtD = 0; RsD = 0; RtD = 0;
        RegWriteE = 0; MemtoRegE = 0; WriteRegE = 0;
        RegWriteM = 0; MemtoRegM = 0; WriteRegM = 0;
        RegWriteW = 0; WriteRegW = 0; FlushD = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clr_inputs();
        sample();
        advance();
        rst_n = 1;
    endtask

    typedef struct {
        logic       br, usert;
        logic [4:0] rs, rt;
        logic       rwe, mte;
        logic [4:0] wre;
        logic       rwm, mtm;
        logic [4:0] wrm;
        logic       rww;
        logic [4:0] wrw;
        int         e_stall, e_res, e_fa, e_fb;
    } vec_t;

    vec_t tbl[13];

    initial begin
        rst_n = 0;
        clr_inputs();
        m_bc = 0;
        m_sc = 0;
        @(negedge clk);

        // Reset with a load-use branch present: outputs must stay quiet
        rst_n = 0;
        BranchD = 1; UseRtD = 1; RsD = 1; RtD = 2;
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 1;
        sample();
        chk("reset_stall", int'(StallD), 0);
        advance();
        rst_n = 1;
        clr_inputs();
        sample();
        chk("reset_branch_count", int'(BranchCount), 0);
        chk("reset_stall_cycles", int'(StallCycles), 0);
        advance();

        //          br usert rs rt rwe mte wre rwm mtm wrm rww wrw  stall res fa fb
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 2, 1, 1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 2, 1, 1, 2, 0, 0, 0, 0, 0,  0, 1, 0, 0};
        tbl[4]  = '{1, 0, 3, 0, 1, 0, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0};
        tbl[5]  = '{1, 1, 1, 2, 0, 0, 0, 1, 1, 2, 0, 0,  1, 0, 0, 0};
        tbl[6]  = '{1, 1, 1, 2, 0, 0, 0, 1, 0, 1, 1, 2,  0, 1, 1, 2};
        tbl[7]  = '{1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2,  0, 1, 0, 0};
        tbl[8]  = '{1, 1, 4, 4, 1, 0, 5, 1, 0, 4, 0, 0,  0, 1, 1, 1};
        tbl[9]  = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0,  0, 1, 0, 0};
        tbl[10] = '{0, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[11] = '{1, 1, 2, 3, 1, 0, 9, 1, 1, 3, 0, 0,  1, 0, 0, 0};
        tbl[12] = '{1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1,  1, 0, 2, 0};

        for (int i = 0; i < 13; i++) begin
            BranchD = tbl[i].br; UseRtD = tbl[i].usert;
            RsD = tbl[i].rs; RtD = tbl[i].rt;
            RegWriteE = tbl[i].rwe; MemtoRegE = tbl[i].mte; WriteRegE = tbl[i].wre;
            RegWriteM = tbl[i].rwm; MemtoRegM = tbl[i].mtm; WriteRegM = tbl[i].wrm;
            RegWriteW = tbl[i].rww; WriteRegW = tbl[i].wrw;
            FlushD = 0;
            sample();
            chk($sformatf("tbl%0d_stall", i), int'(StallD), tbl[i].e_stall);
            chk($sformatf("tbl%0d_resolve", i), int'(BranchResolve), tbl[i].e_res);
            chk($sformatf("tbl%0d_fwd_a", i), int'(FwdAD), tbl[i].e_fa);
            chk($sformatf("tbl%0d_fwd_b", i), int'(FwdBD), tbl[i].e_fb);
            advance();
            clr_inputs();
            FlushD = 1;
            sample();
            advance();
        end

        // lw $1 in EX, beq $1,$2: two stalls then resolve from WB
        do_reset();
        BranchD = 1; UseRtD = 1; RsD = 1; RtD = 2;
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 1;
        sample();
        chk("lu_c1_stall", int'(StallD), 1);
        advance();
        RegWriteE = 0; MemtoRegE = 0; WriteRegE = 0;
        RegWriteM = 1; MemtoRegM = 1; WriteRegM = 1;
        sample();
        chk("lu_c2_stall", int'(FlushE), 1);
        advance();
        RegWriteM = 0; MemtoRegM = 0; WriteRegM = 0;
        RegWriteW = 1; WriteRegW = 1;
        sample();
        chk("lu_c3_stall", int'(StallD), 0);
        chk("lu_c3_resolve", int'(BranchResolve), 1);
        chk("lu_c3_fwd_a", int'(FwdAD), 2);
        advance();
        clr_inputs();
        sample();
        chk("lu_stall_cycles", int'(StallCycles), 2);
        chk("lu_branch_count", int'(BranchCount), 1);
        advance();

        // addu $3 in EX, bgtz $3: one stall then resolve from MEM
        do_reset();
        BranchD = 1; RsD = 3; RtD = 7;
        RegWriteE = 1; WriteRegE = 3;
        sample();
        chk("alu_c1_stall", int'(StallF), 1);
        advance();
        RegWriteE = 0; WriteRegE = 0;
        RegWriteM = 1; MemtoRegM = 0; WriteRegM = 3;
        sample();
        chk("alu_c2_stall", int'(StallD), 0);
        chk("alu_c2_resolve", int'(BranchResolve), 1);
        chk("alu_c2_fwd_a", int'(FwdAD), 1);
        advance();

        // beq $4,$5 with $4 in both MEM and WB
        clr_inputs();
        BranchD = 1; UseRtD = 1; RsD = 4; RtD = 5;
        RegWriteM = 1; WriteRegM = 4; RegWriteW = 1; WriteRegW = 4;
        sample();
        chk("mw_fwd_a", int'(FwdAD), 1);
        chk("mw_fwd_b", int'(FwdBD), 0);
        chk("mw_stall", int'(StallD), 0);
        advance();

        // lw $0 in EX, beq $0,$6
        clr_inputs();
        BranchD = 1; UseRtD = 1; RsD = 0; RtD = 6;
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 0;
        sample();
        chk("r0_stall", int'(StallD), 0);
        chk("r0_fwd_a", int'(FwdAD), 0);
        chk("r0_resolve", int'(BranchResolve), 1);
        advance();

        // Flush during the first WAIT2 cycle aborts the stall
        do_reset();
        BranchD = 1; UseRtD = 1; RsD = 1; RtD = 2;
        RegWriteE = 1; MemtoRegE = 1; WriteRegE = 1;
        sample();
        advance();
        RegWriteE = 0; MemtoRegE = 0; RegWriteM = 1; MemtoRegM = 1; WriteRegM = 1;
        FlushD = 1;
        sample();
        chk("fl_stall", int'(StallD), 0);
        chk("fl_resolve", int'(BranchResolve), 0);
        advance();
        clr_inputs();
        sample();
        chk("fl_idle_resolve", int'(BranchResolve), 0);
        chk("fl_idle_stall", int'(StallD), 0);
        chk("fl_branch_count", int'(BranchCount), 0);
        chk("fl_stall_cycles", int'(StallCycles), 1);
        advance();

        // Saturation on the 2-bit instance: 2 stalls, then 3 more
        do_reset();
        for (int s = 0; s < 3; s++) begin
            clr_inputs();
            BranchD = 1; RsD = 1;
            RegWriteE = 1; MemtoRegE = (s != 1); WriteRegE = 1;
            sample();
            advance();
            if (s != 1) begin
                clr_inputs();
                BranchD = 1; RsD = 1;
                sample();
                advance();
            end
            clr_inputs();
            BranchD = 1; RsD = 1;
            sample();
            advance();
            clr_inputs();
            sample();
            chk($sformatf("sat_stall_cycles_%0d", s), int'(StallCycles_2), (s == 0) ? 2 : 3);
            chk($sformatf("sat_branch_count_%0d", s), int'(BranchCount_2), s + 1);
            advance();
        end
        chk("sat_wide_stall_cycles", int'(StallCycles), 5);

        // Randomised traffic against the action-queue model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 99) >= 2);
            BranchD   = ($urandom_range(0, 9) < 6);
            UseRtD    = $urandom_range(0, 1);
            RsD       = 5'($urandom_range(0, 3));
            RtD       = 5'($urandom_range(0, 3));
            RegWriteE = $urandom_range(0, 1);
            MemtoRegE = $urandom_range(0, 1);
            WriteRegE = 5'($urandom_range(0, 3));
            RegWriteM = $urandom_range(0, 1);
            MemtoRegM = $urandom_range(0, 1);
            WriteRegM = 5'($urandom_range(0, 3));
            RegWriteW = $urandom_range(0, 1);
            WriteRegW = 5'($urandom_range(0, 3));
            FlushD    = ($urandom_range(0, 99) < 5);
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Decode-stage scheduler for the branch comparator in the 5-stage MIPS pipeline. Each cycle it checks whether the operands of a branch sitting in ID (beq/bgtz/bgezal) are ready. It then either selects the forwarding source for each comparator input, or stalls IF/ID and bubbles EX for a counted number of cycles until the producer reaches a forwardable stage. It also keeps saturating performance counters for branches and branch-stall cycles.

## Interface
- `STALL_CNT_W`, default 16: width of the performance counters.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low; clears the FSM and counters.
- `BranchD`  in  1  a branch (beq, bgtz or bgezal) is valid in ID.
- `UseRtD`  in  1  the branch compares Rt (beq). It is 0 for bgtz and bgezal.
- `RsD`, `RtD`  in  5  source registers in ID.
- `RegWriteE`, `MemtoRegE`  in  1 each  EX-stage write enable and load flag.
- `WriteRegE`  in  5  EX-stage destination register.
- `RegWriteM`, `MemtoRegM`  in  1 each  MEM-stage write enable and load flag.
- `WriteRegM`  in  5  MEM-stage destination register.
- `RegWriteW`  in  1  WB-stage write enable.
- `WriteRegW`  in  5  WB-stage destination register.
- `FlushD`  in  1  external ID flush (exception/redirect); aborts any stall.
- `StallF`, `StallD`  out  1 each  hold PC and the IF/ID register.
- `FlushE`  out  1  insert a bubble into ID/EX.
- `FwdAD`, `FwdBD`  out  2 each  comparator input selects: 0 = register file, 1 = ALUResultM, 2 = WData.
- `BranchResolve`  out  1  comparator operands are final this cycle; the branch outcome may be used.
- `BranchCount`  out  STALL_CNT_W  resolved branches, saturating.
- `StallCycles`  out  STALL_CNT_W  cycles spent stalled on branches, saturating.

## Operation
- A register is "used" when it is Rs (always) or Rt (only if UseRtD). Register 0 never matches, so it never causes a hazard and is never forwarded.
- Stall demand N, evaluated only in state IDLE with BranchD=1 and FlushD=0:
  - N=2 if a used register matches WriteRegE with RegWriteE=1 and MemtoRegE=1.
  - Otherwise N=1 if it matches WriteRegE with RegWriteE=1 (ALU result in EX), or matches WriteRegM with RegWriteM=1 and MemtoRegM=1 (load in MEM).
  - Otherwise N=0.
- FSM states are IDLE, WAIT2 and WAIT1.
  - IDLE with N=0: no stall; BranchResolve=BranchD.
  - IDLE with N=2: assert the stall, go to WAIT2.
  - IDLE with N=1: assert the stall, go to WAIT1.
  - WAIT2: assert the stall, go to WAIT1. Hazard equations are not re-evaluated.
  - WAIT1: no stall. The operand is now forwardable. BranchResolve=1, go to IDLE.
- "Assert the stall" means StallF=StallD=FlushE=1, combinational (Mealy) in the cycle the state or decision applies.
- Forwarding is combinational in every state. For each operand:
  - 1 if it matches WriteRegM with RegWriteM=1 and MemtoRegM=0.
  - Else 2 if it matches WriteRegW with RegWriteW=1.
  - Else 0.
  - MEM has priority over WB.
  - FwdBD is 0 whenever UseRtD=0.
- Counters:
  - BranchCount increments on each cycle with BranchResolve=1.
  - StallCycles increments on each cycle with StallD=1.
  - Both saturate at all-ones and do not wrap.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE and both counters=0. Stall and flush outputs are 0 while reset is applied (combinational outputs are gated by state=IDLE and reset).
- Stall latency: a load-use branch stalls exactly 2 cycles and resolves in the 3rd. An ALU-in-EX or load-in-MEM branch stalls 1 cycle and resolves in the 2nd.
- FlushD=1 has priority in any state:
  - Outputs: no stall, BranchResolve=0.
  - Next state: IDLE.
  - Counters: unchanged that cycle.
- FlushD arriving mid-WAIT2 aborts the remaining stall.
- BranchD dropping to 0 in WAIT states does not cancel the countdown (ID is held, so it cannot legally drop). Only FlushD or reset cancels it.
- Reset asserted mid-stall: IDLE on the next edge; the counters clear.

## Structure
- Shared package `mips_pkg`: FSM state encoding, forward-select constants (FWD_RF, FWD_M, FWD_W), and the register-0 constant.
- One natural sub-module, `sat_counter`, instantiated twice for the performance counters.

## Test plan
- lw $1 in EX, beq $1,$2 in ID → StallD=FlushE=1 for 2 cycles, then BranchResolve=1 with FwdAD=2; StallCycles=2, BranchCount=1.
- addu $3 in EX, bgtz $3 in ID → 1 stall cycle, then FwdAD=1 and BranchResolve=1.
- beq $4,$5 with $4 written in both M (ALU) and W → FwdAD=1 (MEM wins), FwdBD=0, no stall.
- lw $0 in EX, beq $0,$6 in ID → no stall, FwdAD=0.
- Load-use stall, FlushD=1 in the first WAIT2 cycle → stall deasserts that cycle, IDLE next, BranchCount unchanged.
- Force StallCycles to 0xFFFE, run 3 stall cycles → it holds at 0xFFFF.
